johnson_phase_monitor: RTL and testbench

- Consumes the 4-bit Johnson counter output on the same clock.
- Decodes the current code to a phase index and a one-hot phase vector.
- Checks that every code is legal and that successive samples advance correctly; counts completed rotations.
- Sits directly downstream of the Johnson counter and feeds phase-driven control logic plus a status register.

---
 rtl/johnson_pkg.sv | 34 +++
 rtl/johnson_phase_monitor_decode.sv | 38 +++
 rtl/johnson_phase_monitor.sv | 132 +++++++++++++
 tb/tb_johnson_phase_monitor.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/johnson_pkg.sv
// Shared types and code/phase helpers for the Johnson phase monitor.
package johnson_pkg;

  localparam int JOHNSON_N  = 4;
  localparam int NUM_PHASES = 2 * JOHNSON_N;
  localparam int PHASE_W    = $clog2(NUM_PHASES);

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  // Ones fill from the MSB for phases 0..N, then drain from the MSB.
  function automatic logic [JOHNSON_N-1:0] phase_to_code(input logic [PHASE_W-1:0] p);
    logic [JOHNSON_N-1:0] ones;
    int k;
    ones = '1;
    k = int'(p);
    if (k <= JOHNSON_N) return ~(ones >> k);
    else return ones >> (k - JOHNSON_N);
  endfunction

  // Returns {legal, phase}; phase is 0 for an illegal code.
  function automatic logic [PHASE_W:0] code_to_phase(input logic [JOHNSON_N-1:0] code);
    logic [PHASE_W:0] res;
    res = '0;
    for (int k = 0; k < NUM_PHASES; k++) begin
      if (code == phase_to_code(PHASE_W'(k))) res = {1'b1, PHASE_W'(k)};
    end
    return res;
  endfunction

endpackage

// File: rtl/johnson_phase_monitor_decode.sv
// Combinational Johnson code decoder: legality flag, phase index and one-hot phase.
module johnson_decode
  import johnson_pkg::*;
#(
  parameter int N = JOHNSON_N,
  localparam int NP = 2 * N,
  localparam int PW = $clog2(NP)
) (
  input  logic [N-1:0]  i_code,
  output logic          o_legal,
  output logic [PW-1:0] o_phase,
  output logic [NP-1:0] o_onehot
);

  localparam logic [N-1:0] ONES = '1;

  logic [NP-1:0] w_match;

  genvar gi;
  generate
    for (gi = 0; gi < NP; gi++) begin : g_match
      localparam logic [N-1:0] CODE = (gi <= N) ? ~(ONES >> gi) : (ONES >> (gi - N));
      assign w_match[gi] = (i_code == CODE);
    end
  endgenerate

  // At most one match, so OR-ing the indices yields the encoded phase.
  always_comb begin
    o_phase = '0;
    for (int k = 0; k < NP; k++) begin
      if (w_match[k]) o_phase = o_phase | PW'(k);
    end
  end

  assign o_legal  = |w_match;
  assign o_onehot = w_match;

endmodule

// File: rtl/johnson_phase_monitor.sv
// Tracks a Johnson counter: registered phase decode, sequence checking,
// sticky error flags and a saturating rotation counter.
module johnson_phase_monitor
  import johnson_pkg::*;
#(
  parameter int N     = JOHNSON_N,
  parameter int CYC_W = 8,
  localparam int NP   = 2 * N,
  localparam int PW   = $clog2(NP)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     cnt_in,
  input  logic             clr_err,
  output logic [PW-1:0]    phase,
  output logic [NP-1:0]    phase_onehot,
  output logic             phase_valid,
  output logic             wrap_pulse,
  output logic [CYC_W-1:0] cycle_count,
  output logic             illegal_code,
  output logic             seq_error
);

  logic          w_legal;
  logic [PW-1:0] w_dec_phase;
  logic [NP-1:0] w_dec_onehot;

  johnson_decode #(.N(N)) u_decode (
    .i_code   (cnt_in),
    .o_legal  (w_legal),
    .o_phase  (w_dec_phase),
    .o_onehot (w_dec_onehot)
  );

  state_t           r_state, w_state_next;
  logic [PW-1:0]    r_phase, w_phase_next;   // doubles as prev_phase
  logic [NP-1:0]    r_onehot, w_onehot_next;
  logic             r_valid, w_valid_next;
  logic             r_wrap, w_wrap_next;
  logic [CYC_W-1:0] r_cycles, w_cycles_next;
  logic             r_illegal, w_illegal_next;
  logic             r_seq, w_seq_next;

  logic [PW-1:0] w_phase_inc;
  assign w_phase_inc = PW'(r_phase + PW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= SYNC;
      r_phase   <= '0;
      r_onehot  <= '0;
      r_valid   <= 1'b0;
      r_wrap    <= 1'b0;
      r_cycles  <= '0;
      r_illegal <= 1'b0;
      r_seq     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_phase   <= w_phase_next;
      r_onehot  <= w_onehot_next;
      r_valid   <= w_valid_next;
      r_wrap    <= w_wrap_next;
      r_cycles  <= w_cycles_next;
      r_illegal <= w_illegal_next;
      r_seq     <= w_seq_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_phase_next   = r_phase;
    w_onehot_next  = r_onehot;
    w_valid_next   = r_valid;
    w_wrap_next    = 1'b0;
    w_cycles_next  = r_cycles;
    w_illegal_next = r_illegal;
    w_seq_next     = r_seq;
    unique case (r_state)
      SYNC: begin
        if (w_legal) begin
          w_phase_next  = w_dec_phase;
          w_onehot_next = w_dec_onehot;
          w_valid_next  = 1'b1;
          w_state_next  = TRACK;
        end else begin
          w_illegal_next = 1'b1;
          w_onehot_next  = '0;
          w_valid_next   = 1'b0;
          w_state_next   = FAULT;
        end
      end
      TRACK: begin
        if (!w_legal) begin
          w_illegal_next = 1'b1;
          w_onehot_next  = '0;
          w_valid_next   = 1'b0;
          w_state_next   = FAULT;
        end else if (w_dec_phase == w_phase_inc) begin
          w_phase_next  = w_dec_phase;
          w_onehot_next = w_dec_onehot;
          if (r_phase == PW'(NP - 1)) begin
            w_wrap_next = 1'b1;
            if (r_cycles != '1) w_cycles_next = CYC_W'(r_cycles + CYC_W'(1));
          end
        end else if (w_dec_phase != r_phase) begin
          w_seq_next    = 1'b1;
          w_onehot_next = '0;
          w_valid_next  = 1'b0;
          w_state_next  = FAULT;
        end
      end
      FAULT: begin
        // The sample taken alongside clr_err is discarded; resync starts next edge.
        if (clr_err) begin
          w_illegal_next = 1'b0;
          w_seq_next     = 1'b0;
          w_state_next   = SYNC;
        end
      end
      default: w_state_next = SYNC;
    endcase
  end

  assign phase        = r_phase;
  assign phase_onehot = r_onehot;
  assign phase_valid  = r_valid;
  assign wrap_pulse   = r_wrap;
  assign cycle_count  = r_cycles;
  assign illegal_code = r_illegal;
  assign seq_error    = r_seq;

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Directed self-checking bench; a CYC_W=2 copy shares the stimulus to exercise saturation.
module tb_johnson_phase_monitor;
  import johnson_pkg::*;

  logic       clk;
  logic       rst;
  logic [3:0] cnt_in;
  logic       clr_err;

  logic [2:0] phase, phase2;
  logic [7:0] phase_onehot, phase_onehot2;
  logic       phase_valid, phase_valid2;
  logic       wrap_pulse, wrap_pulse2;
  logic [7:0] cycle_count;
  logic [1:0] cycle_count2;
  logic       illegal_code, illegal_code2;
  logic       seq_error, seq_error2;

  int n_tests = 0;
  int n_fail  = 0;

  johnson_phase_monitor #(.N(4), .CYC_W(8)) dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .clr_err(clr_err),
    .phase(phase), .phase_onehot(phase_onehot), .phase_valid(phase_valid),
    .wrap_pulse(wrap_pulse), .cycle_count(cycle_count),
    .illegal_code(illegal_code), .seq_error(seq_error)
  );

  johnson_phase_monitor #(.N(4), .CYC_W(2)) dut2 (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .clr_err(clr_err),
    .phase(phase2), .phase_onehot(phase_onehot2), .phase_valid(phase_valid2),
    .wrap_pulse(wrap_pulse2), .cycle_count(cycle_count2),
    .illegal_code(illegal_code2), .seq_error(seq_error2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Packed view {phase, onehot, valid, wrap, illegal, seq} of the main instance.
  function automatic logic [14:0] status();
    return {phase, phase_onehot, phase_valid, wrap_pulse, illegal_code, seq_error};
  endfunction

  function automatic logic [14:0] mk(input int p, input logic oh_on, input logic v,
                                     input logic w, input logic ill, input logic sq);
    logic [7:0] oh;
    oh = oh_on ? 8'(1 << p) : 8'h00;
    return {3'(p), oh, v, w, ill, sq};
  endfunction

  task automatic drive(input logic [3:0] code, input logic clr);
    cnt_in  = code;
    clr_err = clr;
    @(posedge clk);
    #1;
    $display("[TB] t=%0t code=%b clr=%b phase=%0d oh=%b valid=%b wrap=%b cyc=%0d/%0d ill=%b seq=%b",
             $time, code, clr, phase, phase_onehot, phase_valid, wrap_pulse,
             cycle_count, cycle_count2, illegal_code, seq_error);
  endtask

  task automatic test_reset();
    rst = 1'b1; cnt_in = 4'b0000; clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({status(), cycle_count} !== {15'h0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_state: got status=%h cyc=%0d expected status=0 cyc=0", status(), cycle_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_rotation();
    logic [3:0] codes [9] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111,
                              4'b0111, 4'b0011, 4'b0001, 4'b0000};
    int exp_p [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
    logic [14:0] exp;
    for (int i = 0; i < 9; i++) begin
      drive(codes[i], 1'b0);
      exp = mk(exp_p[i], 1'b1, 1'b1, (i == 8), 1'b0, 1'b0);
      n_tests++;
      if (status() !== exp) begin
        n_fail++;
        $display("FAIL rotation_step%0d: got status=%h expected %h", i, status(), exp);
      end
      n_tests++;
      if (cycle_count !== 8'((i == 8) ? 1 : 0)) begin
        n_fail++;
        $display("FAIL rotation_cycles%0d: got %0d expected %0d", i, cycle_count, (i == 8) ? 1 : 0);
      end
    end
  endtask

  task automatic test_stall();
    drive(4'b1000, 1'b0);
    drive(4'b1100, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(4'b1100, 1'b0);
      n_tests++;
      if (status() !== mk(2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0)) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got status=%h expected %h", i, status(),
                 mk(2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
      end
    end
  endtask

  task automatic test_illegal();
    drive(4'b1010, 1'b0);
    n_tests++;
    if (status() !== mk(2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0)) begin
      n_fail++;
      $display("FAIL illegal_detect: got status=%h expected %h", status(), mk(2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    end
    drive(4'b1010, 1'b1);
    n_tests++;
    if (status() !== mk(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)) begin
      n_fail++;
      $display("FAIL illegal_clear: got status=%h expected %h", status(), mk(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    drive(4'b0111, 1'b0);
    n_tests++;
    if (status() !== mk(5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0)) begin
      n_fail++;
      $display("FAIL illegal_resync: got status=%h expected %h", status(), mk(5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    end
  endtask

  task automatic test_seq_error();
    drive(4'b0011, 1'b0);
    drive(4'b0001, 1'b0);
    drive(4'b0000, 1'b0);
    n_tests++;
    if ({wrap_pulse, cycle_count, cycle_count2} !== {1'b1, 8'd2, 2'd2}) begin
      n_fail++;
      $display("FAIL seq_prewrap: got wrap=%b cyc=%0d cyc2=%0d expected wrap=1 cyc=2 cyc2=2",
               wrap_pulse, cycle_count, cycle_count2);
    end
    drive(4'b1000, 1'b0);
    drive(4'b1100, 1'b0);
    drive(4'b1110, 1'b0);
    drive(4'b0011, 1'b0);
    n_tests++;
    if (status() !== mk(3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)) begin
      n_fail++;
      $display("FAIL seq_jump: got status=%h expected %h", status(), mk(3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    end
    drive(4'b1010, 1'b1);
    n_tests++;
    if (status() !== mk(3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)) begin
      n_fail++;
      $display("FAIL seq_clear_with_bad: got status=%h expected %h", status(), mk(3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    // A legal code accepted here proves the FSM is in SYNC, not FAULT.
    drive(4'b1110, 1'b0);
    n_tests++;
    if (status() !== mk(3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0)) begin
      n_fail++;
      $display("FAIL seq_resync: got status=%h expected %h", status(), mk(3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    end
  endtask

  task automatic test_saturation();
    int p;
    int wraps = 0;
    int exp_c2;
    for (int s = 0; s < 40; s++) begin
      p = (4 + s) % 8;
      drive(phase_to_code(3'(p)), 1'b0);
      if (p == 0) wraps++;
      exp_c2 = (2 + wraps > 3) ? 3 : 2 + wraps;
      n_tests++;
      if ({phase, wrap_pulse, wrap_pulse2, cycle_count, cycle_count2} !==
          {3'(p), (p == 0), (p == 0), 8'(2 + wraps), 2'(exp_c2)}) begin
        n_fail++;
        $display("FAIL sat_step%0d: got phase=%0d wrap=%b wrap2=%b cyc=%0d cyc2=%0d expected phase=%0d wrap=%b cyc=%0d cyc2=%0d",
                 s, phase, wrap_pulse, wrap_pulse2, cycle_count, cycle_count2,
                 p, (p == 0), 2 + wraps, exp_c2);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(4'b1111, 1'b0);
    drive(4'b0111, 1'b0);
    n_tests++;
    if (status() !== mk(5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0)) begin
      n_fail++;
      $display("FAIL arst_prephase: got status=%h expected %h", status(), mk(5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({status(), cycle_count, phase2, phase_valid2, cycle_count2} !== '0) begin
      n_fail++;
      $display("FAIL arst_clear: got status=%h cyc=%0d phase2=%0d valid2=%b cyc2=%0d expected all 0",
               status(), cycle_count, phase2, phase_valid2, cycle_count2);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    drive(4'b0001, 1'b0);
    n_tests++;
    if ({status(), cycle_count} !== {mk(7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), 8'd0}) begin
      n_fail++;
      $display("FAIL arst_sync7: got status=%h cyc=%0d expected %h cyc=0", status(), cycle_count,
               mk(7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    end
    drive(4'b0000, 1'b0);
    n_tests++;
    if ({status(), cycle_count, cycle_count2} !== {mk(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0), 8'd1, 2'd1}) begin
      n_fail++;
      $display("FAIL arst_wrap: got status=%h cyc=%0d cyc2=%0d expected %h cyc=1 cyc2=1",
               status(), cycle_count, cycle_count2, mk(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_stall();
    test_illegal();
    test_seq_error();
    test_saturation();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
